// File: rtl/muldiv_seq_if.sv
// -----------------------------------------------------------------------------
// muldiv_seq_if
// Handshake between the execute stage and the iterative multiply/divide
// sequencer.
//   master : execute stage -- drives req_valid, op, word, a, b, flush, stall_in
//   slave  : muldiv_seq    -- drives stall_out, done, result
// Signals:
//   req_valid  valid M-extension instruction held in execute (level)
//   op[2:0]    000 MUL, 100 DIV, 101 DIVU, 110 REM, 111 REMU (001-011 reserved)
//   word       W variant (32-bit operands, sign-extended result)
//   a, b       rs1 / rs2 operands
//   flush      kill the in-flight operation (branch redirect)
//   stall_in   downstream stall; a finished result is not consumed while high
//   stall_out  holds execute while an operation is outstanding
//   done       result valid
//   result     final result, stable while done is high
// -----------------------------------------------------------------------------
interface muldiv_seq_if #(
   parameter int XLEN = 64
);
   logic            req_valid;
   logic [2:0]      op;
   logic            word;
   logic [XLEN-1:0] a;
   logic [XLEN-1:0] b;
   logic            flush;
   logic            stall_in;
   logic            stall_out;
   logic            done;
   logic [XLEN-1:0] result;

   modport master (
      output req_valid, op, word, a, b, flush, stall_in,
      input  stall_out, done, result
   );

   modport slave (
      input  req_valid, op, word, a, b, flush, stall_in,
      output stall_out, done, result
   );
endinterface

// File: rtl/muldiv_seq.sv
// -----------------------------------------------------------------------------
// muldiv_seq
// Iterative radix-2 multiply/divide sequencer for the execute stage
// (RV64M MUL/DIV/DIVU/REM/REMU including W forms). One product or quotient bit
// is produced per cycle; execute is held via stall_out until the result is
// presented, and the result is held while the downstream stage stalls.
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   bus      muldiv_seq_if.slave (request, operands, flush, stalls, result)
// Optional feature:
//   MULDIV_EARLY_OUT_EN  when defined, divide-by-zero, signed overflow and MUL
//                        with a zero operand finish straight from IDLE without
//                        iterating. Results are identical either way.
// -----------------------------------------------------------------------------
module muldiv_seq #(
   parameter int XLEN  = 64,
   parameter int CNT_W = 7
) (
   input logic         clk,
   input logic         reset_n,
   muldiv_seq_if.slave bus
);
   localparam int HALF = XLEN / 2;

   localparam logic [2:0] OP_MUL  = 3'b000;
   localparam logic [2:0] OP_DIV  = 3'b100;
   localparam logic [2:0] OP_DIVU = 3'b101;
   localparam logic [2:0] OP_REM  = 3'b110;
   localparam logic [2:0] OP_REMU = 3'b111;

   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       op_q, op_d;
   logic             word_q, word_d;
   logic [XLEN-1:0]  opA_q, opA_d;
   logic [XLEN-1:0]  opB_q, opB_d;
   // MUL: acc = partial product, work = multiplier, shf = multiplicand
   // DIV: acc = partial remainder, work = dividend/quotient, shf = divisor
   logic [XLEN-1:0]  acc_q, acc_d;
   logic [XLEN-1:0]  work_q, work_d;
   logic [XLEN-1:0]  shf_q, shf_d;
   logic [XLEN-1:0]  result_q, result_d;
   logic             blockAccept_q, blockAccept_d;

   logic [XLEN-1:0]  inA, inB, magA, magB;
   logic             inReserved, earlyOut;
   logic [XLEN:0]    remSh, trial;

   function automatic logic isSignedDiv(input logic [2:0] fop);
      return (fop == OP_DIV) || (fop == OP_REM);
   endfunction

   // W ops see a 32-bit operand widened to XLEN: zero-extended for the
   // unsigned divides, sign-extended otherwise.
   function automatic logic [XLEN-1:0] extendOperand(input logic [2:0] fop, input logic fword,
                                                     input logic [XLEN-1:0] x);
      logic [XLEN-1:0] ext;
      ext = x;
      if (fword) begin
         if ((fop == OP_DIVU) || (fop == OP_REMU)) ext = {{HALF{1'b0}}, x[HALF-1:0]};
         else                                      ext = {{HALF{x[HALF-1]}}, x[HALF-1:0]};
      end
      return ext;
   endfunction

   function automatic logic [XLEN-1:0] magnitude(input logic [2:0] fop, input logic [XLEN-1:0] x);
      return (isSignedDiv(fop) && x[XLEN-1]) ? -x : x;
   endfunction

   function automatic logic isOverflow(input logic [2:0] fop, input logic fword,
                                       input logic [XLEN-1:0] fa, input logic [XLEN-1:0] fb);
      logic [XLEN-1:0] minVal;
      minVal = fword ? {{(HALF+1){1'b1}}, {(HALF-1){1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};
      return isSignedDiv(fop) && (fb == '1) && (fa == minVal);
   endfunction

   // Sign fix-up, special-case override and W sign extension of the raw
   // iteration output (fq = product or quotient magnitude, fr = remainder).
   function automatic logic [XLEN-1:0] finalize(input logic [2:0] fop, input logic fword,
                                                input logic [XLEN-1:0] fa, input logic [XLEN-1:0] fb,
                                                input logic [XLEN-1:0] fq, input logic [XLEN-1:0] fr);
      logic [XLEN-1:0] res;
      case (fop)
         OP_MUL: res = fq;
         OP_DIV, OP_DIVU: begin
            if (fb == '0)                           res = '1;
            else if (isOverflow(fop, fword, fa, fb)) res = fa;
            else if (isSignedDiv(fop) && (fa[XLEN-1] != fb[XLEN-1])) res = -fq;
            else                                    res = fq;
         end
         OP_REM, OP_REMU: begin
            if (fb == '0)                           res = fa;
            else if (isOverflow(fop, fword, fa, fb)) res = '0;
            else if (isSignedDiv(fop) && fa[XLEN-1]) res = -fr;
            else                                    res = fr;
         end
         default: res = '0;
      endcase
      if (fword) res = {{HALF{res[HALF-1]}}, res[HALF-1:0]};
      return res;
   endfunction

   assign inA        = extendOperand(bus.op, bus.word, bus.a);
   assign inB        = extendOperand(bus.op, bus.word, bus.b);
   assign magA       = magnitude(bus.op, inA);
   assign magB       = magnitude(bus.op, inB);
   assign inReserved = (bus.op != OP_MUL) && !bus.op[2];

   // Restoring-divide trial subtraction; the extra top bit is the borrow.
   assign remSh = {acc_q, work_q[XLEN-1]};
   assign trial = remSh - {1'b0, shf_q};

`ifdef MULDIV_EARLY_OUT_EN
   assign earlyOut = (bus.op == OP_MUL) ? ((inA == '0) || (inB == '0))
                                        : ((inB == '0) || isOverflow(bus.op, bus.word, inA, inB));
`else
   assign earlyOut = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         op_q          <= '0;
         word_q        <= 1'b0;
         opA_q         <= '0;
         opB_q         <= '0;
         acc_q         <= '0;
         work_q        <= '0;
         shf_q         <= '0;
         result_q      <= '0;
         blockAccept_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         op_q          <= op_d;
         word_q        <= word_d;
         opA_q         <= opA_d;
         opB_q         <= opB_d;
         acc_q         <= acc_d;
         work_q        <= work_d;
         shf_q         <= shf_d;
         result_q      <= result_d;
         blockAccept_q <= blockAccept_d;
      end
   end

   // The counter is loaded with N so that N iteration cycles are followed by
   // one finishing cycle at cnt==0, giving done after edge N+1.
   // blockAccept suppresses acceptance in the cycle right after DONE->IDLE,
   // because execute has just advanced past the finished instruction.
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      op_d          = op_q;
      word_d        = word_q;
      opA_d         = opA_q;
      opB_d         = opB_q;
      acc_d         = acc_q;
      work_d        = work_q;
      shf_d         = shf_q;
      result_d      = result_q;
      blockAccept_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.req_valid && !bus.flush && !blockAccept_q) begin
               op_d   = bus.op;
               word_d = bus.word;
               opA_d  = inA;
               opB_d  = inB;
               cnt_d  = bus.word ? CNT_W'(HALF) : CNT_W'(XLEN);
               acc_d  = '0;
               if (inReserved) begin
                  state_d  = DONE;
                  result_d = '0;
               end else if (earlyOut) begin
                  state_d  = DONE;
                  result_d = finalize(bus.op, bus.word, inA, inB, '0, '0);
               end else if (bus.op == OP_MUL) begin
                  state_d = MUL;
                  work_d  = inB;
                  shf_d   = inA;
               end else begin
                  state_d = DIV;
                  // A W dividend is top-aligned so its MSB shifts out first.
                  work_d  = bus.word ? (magA << HALF) : magA;
                  shf_d   = magB;
               end
            end
         end
         MUL, DIV: begin
            if (bus.flush) begin
               state_d = IDLE;
            end else if (cnt_q == '0) begin
               state_d  = DONE;
               result_d = finalize(op_q, word_q, opA_q, opB_q,
                                   (state_q == MUL) ? acc_q : work_q, acc_q);
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
               if (state_q == MUL) begin
                  acc_d  = work_q[0] ? (acc_q + shf_q) : acc_q;
                  work_d = work_q >> 1;
                  shf_d  = shf_q << 1;
               end else begin
                  acc_d  = trial[XLEN] ? remSh[XLEN-1:0] : trial[XLEN-1:0];
                  work_d = {work_q[XLEN-2:0], ~trial[XLEN]};
               end
            end
         end
         DONE: begin
            if (bus.flush) begin
               state_d = IDLE;
            end else if (!bus.stall_in) begin
               state_d       = IDLE;
               blockAccept_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      bus.stall_out = bus.req_valid && (state_q != DONE);
      bus.done      = (state_q == DONE);
      bus.result    = result_q;
   end
endmodule

// File: tb/tb_muldiv_seq.sv
// -----------------------------------------------------------------------------
// tb_muldiv_seq
// Directed testbench for muldiv_seq. The driver pushes each hand-computed
// expected result into a scoreboard queue when it issues the request; an
// independent monitor pops and compares whenever the DUT hands a result to a
// non-stalled downstream stage.
// -----------------------------------------------------------------------------
module tb_muldiv_seq;
   localparam int XLEN = 64;

   localparam logic [2:0] OP_MUL  = 3'b000;
   localparam logic [2:0] OP_DIV  = 3'b100;
   localparam logic [2:0] OP_DIVU = 3'b101;
   localparam logic [2:0] OP_REM  = 3'b110;
   localparam logic [2:0] OP_REMU = 3'b111;

   logic clk = 1'b0;
   logic reset_n;
   int   checks = 0;
   int   errors = 0;

   logic [XLEN-1:0] sbExp[$];
   string           sbName[$];

   muldiv_seq_if #(.XLEN(XLEN)) bus ();

   muldiv_seq #(.XLEN(XLEN), .CNT_W(7)) dut (
      .clk    (clk),
      .reset_n(reset_n),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%h, expected 0x%h", name, actual, expected);
      end
   endtask

   // Monitor: a result is consumed on any cycle in which done is high and
   // downstream is not stalled.
   always @(negedge clk) begin
      if (reset_n && bus.done && !bus.stall_in && !bus.flush) begin
         if (sbExp.size() == 0) begin
            checkOutput("done_without_request", 64'(sbExp.size()), 64'd1);
         end else begin
            checkOutput(sbName.pop_front(), bus.result, sbExp.pop_front());
         end
      end
   end

   // Issue one request and hold it until the result is consumed.
   // expLatency: edges after the accepting edge until done (-1 = not checked).
   // holdCycles: cycles stall_in is kept high while the result is presented.
   // backToBack: present the request immediately after the previous one.
   task automatic applyStimulus(input string name, input logic [2:0] op, input logic w,
                                input logic [63:0] a, input logic [63:0] b,
                                input logic [63:0] expected, input int expLatency,
                                input int holdCycles, input bit backToBack);
      int          edges;
      int          stallDrops;
      logic [63:0] held;
      sbExp.push_back(expected);
      sbName.push_back(name);
      if (!backToBack) begin
         @(negedge clk);
         @(negedge clk);
      end
      bus.req_valid = 1'b1;
      bus.op        = op;
      bus.word      = w;
      bus.a         = a;
      bus.b         = b;
      bus.stall_in  = (holdCycles > 0);
      edges         = 0;
      stallDrops    = 0;
      while (!bus.done && edges < 200) begin
         @(posedge clk);
         #1;
         edges++;
         if (!bus.done && !bus.stall_out) stallDrops++;
         // Operand changes while busy must not affect the latched copies.
         if (edges == 2) begin
            bus.a  = ~a;
            bus.b  = ~b;
            bus.op = OP_REMU;
         end
      end
      if (!bus.done) begin
         checkOutput({name, "_timeout"}, 64'(bus.done), 64'd1);
         bus.req_valid = 1'b0;
         bus.stall_in  = 1'b0;
         return;
      end
      if (expLatency >= 0) checkOutput({name, "_latency"}, 64'(edges - 1), 64'(expLatency));
      checkOutput({name, "_stall_out_busy"}, 64'(stallDrops), 64'd0);
      checkOutput({name, "_stall_out_done"}, 64'(bus.stall_out), 64'd0);
      held = bus.result;
      for (int i = 0; i < holdCycles; i++) begin
         @(posedge clk);
         #1;
         checkOutput({name, "_hold_done"}, 64'(bus.done), 64'd1);
         checkOutput({name, "_hold_result"}, bus.result, held);
      end
      bus.stall_in = 1'b0;
      @(posedge clk);
      #1;
      checkOutput({name, "_idle_after"}, 64'(bus.done), 64'd0);
      bus.req_valid = 1'b0;
   endtask

   task automatic expectNoDone(input string name, input int cycles);
      int seen;
      seen = 0;
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk);
         #1;
         if (bus.done) seen++;
      end
      checkOutput(name, 64'(seen), 64'd0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      reset_n       = 1'b0;
      bus.req_valid = 1'b0;
      bus.op        = OP_MUL;
      bus.word      = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      bus.flush     = 1'b0;
      bus.stall_in  = 1'b0;
      #12;
      checkOutput("reset_done", 64'(bus.done), 64'd0);
      checkOutput("reset_result", bus.result, 64'd0);
      checkOutput("reset_stall_out_idle", 64'(bus.stall_out), 64'd0);
      bus.req_valid = 1'b1;
      #1;
      checkOutput("reset_stall_out_req", 64'(bus.stall_out), 64'd1);
      bus.req_valid = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;

      applyStimulus("divu_100_7",    OP_DIVU, 1'b0, 64'd100, 64'd7, 64'd14, 65, 0, 1'b0);
      applyStimulus("div_m7_2",      OP_DIV,  1'b0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65, 0, 1'b0);
      applyStimulus("rem_m7_2",      OP_REM,  1'b0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65, 0, 1'b0);
      applyStimulus("div_7_m2",      OP_DIV,  1'b0, 64'd7, -64'sd2, 64'hFFFF_FFFF_FFFF_FFFD, 65, 0, 1'b0);
      applyStimulus("rem_7_m2",      OP_REM,  1'b0, 64'd7, -64'sd2, 64'd1, 65, 0, 1'b0);
      applyStimulus("mulw_7fff_2",   OP_MUL,  1'b1, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 33, 0, 1'b0);
      applyStimulus("mulw_m1_3",     OP_MUL,  1'b1, 64'hFFFF_FFFF, 64'd3, 64'hFFFF_FFFF_FFFF_FFFD, 33, 0, 1'b0);
      applyStimulus("mul_pos",       OP_MUL,  1'b0, 64'h1234_5678, 64'h10, 64'h1_2345_6780, 65, 0, 1'b0);
      applyStimulus("mul_neg",       OP_MUL,  1'b0, -64'sd3, 64'd5, 64'hFFFF_FFFF_FFFF_FFF1, 65, 0, 1'b0);
      applyStimulus("mul_zero",      OP_MUL,  1'b0, 64'd0, 64'hDEAD, 64'd0, -1, 0, 1'b0);
      applyStimulus("divu_max_2",    OP_DIVU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'h7FFF_FFFF_FFFF_FFFF, 65, 0, 1'b0);
      applyStimulus("remu_max_2",    OP_REMU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd1, 65, 0, 1'b0);
      applyStimulus("divw_m7_2",     OP_DIV,  1'b1, 64'h1234_5678_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 33, 0, 1'b0);
      applyStimulus("divuw_big_2",   OP_DIVU, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'd2, 64'h0000_0000_7FFF_FFFC, 33, 0, 1'b0);
      applyStimulus("remuw_big_16",  OP_REMU, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'h10, 64'd9, 33, 0, 1'b0);
      applyStimulus("div_5_0",       OP_DIV,  1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, -1, 0, 1'b0);
      applyStimulus("remw_8000_0",   OP_REM,  1'b1, 64'h8000_0000, 64'd0, 64'hFFFF_FFFF_8000_0000, -1, 0, 1'b0);
      applyStimulus("div_ovf",       OP_DIV,  1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
                    64'h8000_0000_0000_0000, -1, 0, 1'b0);
      applyStimulus("rem_ovf",       OP_REM,  1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
                    64'd0, -1, 0, 1'b0);
      applyStimulus("divw_ovf",      OP_DIV,  1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000, -1, 0, 1'b0);
      applyStimulus("reserved_001",  3'b001,  1'b0, 64'd5, 64'd3, 64'd0, 0, 0, 1'b0);
      // Presented immediately after the previous result was consumed: the
      // first edge is the blocked cycle, acceptance happens on the second.
      applyStimulus("reserved_b2b",  3'b011,  1'b0, 64'd9, 64'd9, 64'd0, 1, 0, 1'b1);
      applyStimulus("div_stall",     OP_DIV,  1'b0, 64'd1000, -64'sd10, 64'hFFFF_FFFF_FFFF_FF9C, 65, 5, 1'b0);

      // Flush ten cycles into a divide: done must never rise for it.
      @(negedge clk);
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.op        = OP_DIVU;
      bus.word      = 1'b0;
      bus.a         = 64'd100;
      bus.b         = 64'd7;
      repeat (11) @(posedge clk);
      #1;
      bus.flush = 1'b1;
      @(posedge clk);
      #1;
      bus.flush     = 1'b0;
      bus.req_valid = 1'b0;
      checkOutput("flush_idle_done", 64'(bus.done), 64'd0);
      expectNoDone("flush_no_done", 80);

      // flush wins over req_valid in the same cycle (reserved op would finish at once).
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.op        = 3'b010;
      bus.flush     = 1'b1;
      @(posedge clk);
      #1;
      bus.flush     = 1'b0;
      bus.req_valid = 1'b0;
      checkOutput("flush_beats_req", 64'(bus.done), 64'd0);
      expectNoDone("flush_beats_req_later", 5);

      // Reset pulse in the middle of a multiply clears the held result at once.
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.op        = OP_MUL;
      bus.a         = 64'd3;
      bus.b         = 64'd5;
      repeat (6) @(posedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      checkOutput("midreset_done", 64'(bus.done), 64'd0);
      checkOutput("midreset_result", bus.result, 64'd0);
      checkOutput("midreset_stall_out", 64'(bus.stall_out), 64'd1);
      bus.req_valid = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      expectNoDone("midreset_no_done", 80);

      repeat (3) @(negedge clk);
      checkOutput("scoreboard_empty", 64'(sbExp.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
